// File: rtl/ifetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifetch_unit                                                |
// | Description : Single-outstanding instruction fetch unit. Requests one    |
// |               word from instruction memory, holds it for decode, decodes |
// |               the opcode and the branch/jump immediate, and stalls the   |
// |               PC stage until decode takes the instruction.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   CLK          in   1   clock, rising edge                               |
// |   RESET        in   1   asynchronous active-high reset                   |
// |   IP           in  32   fetch address from the PC stage                  |
// |   flush        in   1   redirect: discard in-flight / held instruction   |
// |   dec_ready    in   1   decode accepts the held instruction              |
// |   mem_req      out  1   instruction-memory read request                  |
// |   mem_addr     out 32   request word address                             |
// |   mem_ack      in   1   one-cycle read-data-valid strobe                 |
// |   mem_rdata    in  32   read data, valid with mem_ack                    |
// |   instr        out 32   held instruction word                            |
// |   OP           out  7   instr[6:0]                                       |
// |   imm          out 32   sign-extended branch/jump offset                 |
// |   instr_valid  out  1   instr/OP/imm valid for decode                    |
// |   illegal      out  1   held word is not a 32-bit encoding               |
// |   fetch_busy   out  1   PC stage must hold                               |
// +--------------------------------------------------------------------------+
module ifetch_unit (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        IP,
  input  logic               flush,
  input  logic               dec_ready,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic [31:0]        instr,
  output logic [6:0]         OP,
  output logic signed [31:0] imm,
  output logic               instr_valid,
  output logic               illegal,
  output logic               fetch_busy
);

  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        drop_q,  drop_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] instr_q, instr_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      addr_q  <= 32'h0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    mem_req     = 1'b0;
    mem_addr    = 32'h0;
    instr_valid = 1'b0;
    fetch_busy  = 1'b1;

    case (state_q)
      S_IDLE: begin
        addr_d  = IP;
        state_d = S_REQ;
      end

      S_REQ: begin
        // The request is held until the ack; a flush only marks the
        // outstanding response for discard so the memory handshake stays
        // one-request/one-ack.
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          if (flush || drop_q) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            instr_d = mem_rdata;
            state_d = S_VALID;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      S_VALID: begin
        instr_valid = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (dec_ready) begin
          // Decode takes the word this cycle: release the PC for one cycle
          // and launch the next request from the new IP.
          fetch_busy = 1'b0;
          addr_d     = IP;
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign instr   = instr_q;
  assign OP      = instr_q[6:0];
  assign illegal = instr_valid && (instr_q[1:0] != 2'b11);

  always_comb begin
    imm = 32'sh0;
    case (instr_q[6:0])
      c_OP_JAL: imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                       instr_q[20], instr_q[30:21], 1'b0};
      c_OP_BRANCH: imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
      c_OP_JALR: imm = {{20{instr_q[31]}}, instr_q[31:20]};
      default: imm = 32'sh0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ifetch_unit                                             |
// | Description : Self-checking bench for ifetch_unit. Expected instructions |
// |               are queued when the memory response is driven and popped  |
// |               when the DUT presents instr_valid.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ifetch_unit;

  logic        clk;
  logic        RESET;
  logic [31:0] IP;
  logic        flush;
  logic        dec_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [6:0]  OP;
  logic signed [31:0] imm;
  logic        instr_valid;
  logic        illegal;
  logic        fetch_busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  ifetch_unit dut (
    .CLK         (clk),
    .RESET       (RESET),
    .IP          (IP),
    .flush       (flush),
    .dec_ready   (dec_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .OP          (OP),
    .imm         (imm),
    .instr_valid (instr_valid),
    .illegal     (illegal),
    .fetch_busy  (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference immediate decode, written from the instruction-format tables.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    case (w[6:0])
      7'b1101111: ref_imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      7'b1100011: ref_imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      7'b1100111: ref_imm = {{20{w[31]}}, w[31:20]};
      default:    ref_imm = 32'h0;
    endcase
  endfunction

  // Memory model: waits (bounded) for a request, keeps ack low for lat
  // cycles while watching the request stay stable, then returns data.
  task automatic mem_respond(input logic [31:0] data, input int lat,
                             input logic [31:0] eimm,
                             output logic [31:0] addr_seen,
                             output bit timeout, output bit stable);
    exp_t e;
    timeout   = 1'b0;
    stable    = 1'b1;
    addr_seen = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) break;
      @(negedge clk);
    end
    if (!mem_req) begin
      timeout = 1'b1;
      return;
    end
    addr_seen = mem_addr;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (!mem_req || mem_addr !== addr_seen) stable = 1'b0;
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    e.word = data;
    e.imm  = eimm;
    e.ill  = (data[1:0] != 2'b11);
    sb.push_back(e);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; IP = 32'h0; flush = 1'b0; dec_ready = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({mem_req, instr_valid, illegal, fetch_busy} !== 4'b0001) begin
      $display("FAIL reset_outputs: req/valid/illegal/busy=%b required 0001",
               {mem_req, instr_valid, illegal, fetch_busy});
    end else n_pass++;
    n_total++;
    if (instr !== 32'h0 || imm !== 32'sh0) begin
      $display("FAIL reset_instr: instr=%h imm=%h required 0/0", instr, imm);
    end else n_pass++;
    RESET = 1'b0;
  endtask

  task automatic test_first_fetch();
    logic [31:0] a; bit to, st; exp_t e;
    mem_respond(32'h00500093, 2, 32'h0, a, to, st);
    n_total++;
    if (to || !st || a !== 32'h0) begin
      $display("FAIL first_req: timeout=%0d stable=%0d addr=%h required 0/1/0", to, st, a);
    end else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (instr_valid !== 1'b1 || instr !== e.word || OP !== 7'b0010011 || imm !== e.imm) begin
      $display("FAIL first_instr: valid=%b instr=%h op=%b imm=%h required 1 %h 0010011 %h",
               instr_valid, instr, OP, imm, e.word, e.imm);
    end else n_pass++;
  endtask

  task automatic test_hold_jal();
    logic [31:0] a; bit to, st; exp_t e; bit hold_ok;
    dec_ready = 1'b1; IP = 32'h100;
    #1;
    n_total++;
    if (fetch_busy !== 1'b0) $display("FAIL accept_busy: fetch_busy=%b required 0", fetch_busy);
    else n_pass++;
    @(negedge clk);
    dec_ready = 1'b0; IP = 32'hDEAD0000;
    mem_respond(32'h008000EF, 1, 32'd8, a, to, st);
    n_total++;
    if (to || !st || a !== 32'h100) begin
      $display("FAIL jal_req: timeout=%0d stable=%0d addr=%h required 0/1/100", to, st, a);
    end else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (instr_valid !== 1'b1 || instr !== e.word || OP !== 7'b1101111 || imm !== e.imm) begin
      $display("FAIL jal_instr: valid=%b instr=%h op=%b imm=%h required 1 %h 1101111 %h",
               instr_valid, instr, OP, imm, e.word, e.imm);
    end else n_pass++;
    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IP = 32'hBEEF0000 + i;
      @(negedge clk);
      #1;
      if (instr_valid !== 1'b1 || imm !== 32'sd8 || fetch_busy !== 1'b1 ||
          instr !== 32'h008000EF) hold_ok = 1'b0;
    end
    n_total++;
    if (!hold_ok) begin
      $display("FAIL jal_hold: valid=%b imm=%h busy=%b instr=%h required 1 8 1 008000ef",
               instr_valid, imm, fetch_busy, instr);
    end else n_pass++;
    dec_ready = 1'b1; IP = 32'h200;
    #1;
    n_total++;
    if (fetch_busy !== 1'b0) $display("FAIL jal_release: fetch_busy=%b required 0", fetch_busy);
    else n_pass++;
    @(negedge clk);
    dec_ready = 1'b0;
    #1;
    n_total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || fetch_busy !== 1'b1) begin
      $display("FAIL jal_next_req: req=%b addr=%h busy=%b required 1 200 1",
               mem_req, mem_addr, fetch_busy);
    end else n_pass++;
  endtask

  task automatic test_branch();
    logic [31:0] a; bit to, st; exp_t e;
    mem_respond(32'hFE000EE3, 3, 32'hFFFFFFFC, a, to, st);
    n_total++;
    if (to || !st || a !== 32'h200) begin
      $display("FAIL br_req: timeout=%0d stable=%0d addr=%h required 0/1/200", to, st, a);
    end else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (instr_valid !== 1'b1 || OP !== 7'b1100011 || imm !== e.imm || illegal !== 1'b0) begin
      $display("FAIL br_instr: valid=%b op=%b imm=%h illegal=%b required 1 1100011 %h 0",
               instr_valid, OP, imm, illegal, e.imm);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic [31:0] a; bit to, st; exp_t e;
    words[0] = 32'hFFC08067;  // jalr, -4
    words[1] = 32'h00000000;  // not a 32-bit encoding
    words[2] = 32'h800000EF;  // jal, most negative offset
    words[3] = 32'h01F50463;  // beq, positive offset
    for (int i = 0; i < 4; i++) begin
      dec_ready = 1'b1; IP = 32'h1000 + 32'(4 * i);
      #1;
      n_total++;
      if (fetch_busy !== 1'b0) $display("FAIL b2b_busy[%0d]: fetch_busy=%b required 0", i, fetch_busy);
      else n_pass++;
      @(negedge clk);
      dec_ready = 1'b0;
      mem_respond(words[i], 1 + (i % 3), ref_imm(words[i]), a, to, st);
      n_total++;
      if (to || !st || a !== 32'h1000 + 32'(4 * i)) begin
        $display("FAIL b2b_req[%0d]: timeout=%0d stable=%0d addr=%h required 0/1/%h",
                 i, to, st, a, 32'h1000 + 32'(4 * i));
      end else n_pass++;
      e = sb.pop_front();
      n_total++;
      if (instr_valid !== 1'b1 || instr !== e.word || OP !== e.word[6:0] ||
          imm !== e.imm || illegal !== e.ill) begin
        $display("FAIL b2b_instr[%0d]: valid=%b instr=%h imm=%h illegal=%b required 1 %h %h %b",
                 i, instr_valid, instr, imm, illegal, e.word, e.imm, e.ill);
      end else n_pass++;
    end
  endtask

  task automatic test_flush_req();
    logic [31:0] a; bit to, st; exp_t e; bit req_ok;
    dec_ready = 1'b1; IP = 32'h300;
    @(negedge clk);
    dec_ready = 1'b0; flush = 1'b1; IP = 32'h400;
    @(negedge clk);
    flush = 1'b0;
    req_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300) req_ok = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (!req_ok) $display("FAIL flush_req_held: req=%b addr=%h required 1 300", mem_req, mem_addr);
    else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h12345013;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n_total++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      $display("FAIL flush_req_drop: valid=%b req=%b required 0 0", instr_valid, mem_req);
    end else n_pass++;
    mem_respond(32'h00A00113, 2, 32'h0, a, to, st);
    n_total++;
    if (to || !st || a !== 32'h400) begin
      $display("FAIL flush_req_newip: timeout=%0d stable=%0d addr=%h required 0/1/400", to, st, a);
    end else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (instr_valid !== 1'b1 || instr !== e.word) begin
      $display("FAIL flush_req_next: valid=%b instr=%h required 1 %h", instr_valid, instr, e.word);
    end else n_pass++;
  endtask

  task automatic test_flush_ack();
    logic [31:0] a; bit to, st; exp_t e;
    dec_ready = 1'b1; IP = 32'h500;
    @(negedge clk);
    dec_ready = 1'b0; mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'h0FF00093;
    @(negedge clk);
    mem_ack = 1'b0; flush = 1'b0; IP = 32'h600;
    #1;
    n_total++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      $display("FAIL flush_ack_drop: valid=%b req=%b required 0 0", instr_valid, mem_req);
    end else n_pass++;
    mem_respond(32'h00C00193, 1, 32'h0, a, to, st);
    e = sb.pop_front();
    n_total++;
    if (to || a !== 32'h600 || instr_valid !== 1'b1 || instr !== e.word) begin
      $display("FAIL flush_ack_next: timeout=%0d addr=%h valid=%b instr=%h required 0 600 1 %h",
               to, a, instr_valid, instr, e.word);
    end else n_pass++;
    flush = 1'b1; dec_ready = 1'b1;
    #1;
    n_total++;
    if (fetch_busy !== 1'b1) $display("FAIL flush_valid_busy: fetch_busy=%b required 1", fetch_busy);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0; dec_ready = 1'b0;
    #1;
    n_total++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      $display("FAIL flush_valid_drop: valid=%b req=%b required 0 0", instr_valid, mem_req);
    end else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [31:0] a; bit to, st; exp_t e;
    @(negedge clk);
    #1;
    n_total++;
    if (mem_req !== 1'b1) $display("FAIL areset_pre: mem_req=%b required 1", mem_req);
    else n_pass++;
    #1;
    RESET = 1'b1;
    #1;
    n_total++;
    if (mem_req !== 1'b0 || fetch_busy !== 1'b1 || instr_valid !== 1'b0) begin
      $display("FAIL areset_now: req=%b busy=%b valid=%b required 0 1 0",
               mem_req, fetch_busy, instr_valid);
    end else n_pass++;
    IP = 32'h700;
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;
    mem_respond(32'h00000013, 1, 32'h0, a, to, st);
    e = sb.pop_front();
    n_total++;
    if (to || a !== 32'h700 || instr_valid !== 1'b1 || instr !== e.word) begin
      $display("FAIL areset_after: timeout=%0d addr=%h valid=%b instr=%h required 0 700 1 %h",
               to, a, instr_valid, instr, e.word);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_jal();
    test_branch();
    test_back_to_back();
    test_flush_req();
    test_flush_ack();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
